// File: rtl/clock_set_ctrl_if.sv
// Button, timekeeper and display-side signals of the time-setting controller.
interface clock_set_ctrl_if;
  logic        btn_mode;
  logic        btn_inc;
  logic [23:0] time_in;
  logic        run;
  logic        load;
  logic [23:0] time_out;
  logic [5:0]  blank;
  logic [1:0]  mode;

  modport master (output btn_mode, btn_inc, time_in,
                  input  run, load, time_out, blank, mode);
  modport slave  (input  btn_mode, btn_inc, time_in,
                  output run, load, time_out, blank, mode);
endinterface

// File: rtl/clock_set_ctrl.sv
// HH-MM-SS time-setting controller: debounced buttons, edit FSM, commit load,
// timekeeper freeze and blink mask for the field under edit.
module clock_set_ctrl_db #(
  parameter int DEBOUNCE_CYCLES = 640000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic          lvl, lvl_d;
  logic [CW-1:0] cnt;

  // lvl follows sync[1] only after DEBOUNCE_CYCLES consecutive disagreeing cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      lvl   <= 1'b0;
      lvl_d <= 1'b0;
      cnt   <= '0;
    end else begin
      sync  <= {sync[0], btn};
      lvl_d <= lvl;
      if (sync[1] == lvl)                         cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        lvl <= sync[1];
        cnt <= '0;
      end else                                    cnt <= cnt + 1'b1;
    end
  end

  assign press = lvl & ~lvl_d;
endmodule

module clock_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 640000,
  parameter int BLINK_HALF      = 16000000,
  parameter int TIMEOUT_CYCLES  = 960000000
) (
  input  logic             clk,
  input  logic             rst,
  clock_set_ctrl_if.slave  bus
);
  localparam int NUM_BTN = 2;
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {RUN = 2'd0, SET_HH = 2'd1, SET_MM = 2'd2, SET_SS = 2'd3} state_t;

  logic [NUM_BTN-1:0] btn_raw, press;
  logic               p_mode, p_inc;

  assign btn_raw = {bus.btn_inc, bus.btn_mode};

  genvar g;
  generate
    for (g = 0; g < NUM_BTN; g++) begin : g_db
      clock_set_ctrl_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk(clk), .rst(rst), .btn(btn_raw[g]), .press(press[g]));
    end
  endgenerate

  assign p_mode = press[0];
  assign p_inc  = press[1];

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)          return 8'h00;
    if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Once both nibbles are decimal, a plain byte compare against the BCD limit is exact
  function automatic logic [7:0] bcd_fix(input logic [7:0] v, input logic [7:0] max);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > max) return 8'h00;
    return v;
  endfunction

  state_t        state, state_nxt;
  logic [23:0]   edit, edit_nxt;
  logic [BW-1:0] blink_cnt, blink_cnt_nxt;
  logic          phase, phase_nxt;
  logic [TW-1:0] to_cnt, to_cnt_nxt;
  logic          load_nxt, load_q, run_q;
  logic [5:0]    blank_nxt, blank_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      edit      <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      to_cnt    <= '0;
      load_q    <= 1'b0;
      run_q     <= 1'b1;
      blank_q   <= '0;
    end else begin
      state     <= state_nxt;
      edit      <= edit_nxt;
      blink_cnt <= blink_cnt_nxt;
      phase     <= phase_nxt;
      to_cnt    <= to_cnt_nxt;
      load_q    <= load_nxt;
      run_q     <= (state_nxt == RUN);
      blank_q   <= blank_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    edit_nxt      = edit;
    load_nxt      = 1'b0;
    blink_cnt_nxt = blink_cnt;
    phase_nxt     = phase;
    to_cnt_nxt    = to_cnt;
    blank_nxt     = '0;

    // p_mode has priority over p_inc, and any press beats the timeout
    case (state)
      RUN: if (p_mode) begin
        state_nxt = SET_HH;
        edit_nxt  = {bcd_fix(bus.time_in[23:16], 8'h23),
                     bcd_fix(bus.time_in[15:8],  8'h59),
                     bcd_fix(bus.time_in[7:0],   8'h59)};
      end
      default: begin
        if (p_mode) begin
          case (state)
            SET_HH:  state_nxt = SET_MM;
            SET_MM:  state_nxt = SET_SS;
            default: begin
              state_nxt = RUN;
              load_nxt  = 1'b1;
            end
          endcase
        end else if (p_inc) begin
          case (state)
            SET_HH:  edit_nxt[23:16] = bcd_inc(edit[23:16], 8'h23);
            SET_MM:  edit_nxt[15:8]  = bcd_inc(edit[15:8],  8'h59);
            default: edit_nxt[7:0]   = 8'h00;
          endcase
        end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = RUN;
        end
      end
    endcase

    if (state_nxt == RUN) begin
      to_cnt_nxt    = '0;
      blink_cnt_nxt = '0;
      phase_nxt     = 1'b0;
    end else begin
      to_cnt_nxt = (p_mode || p_inc || state == RUN) ? '0 : to_cnt + 1'b1;
      if (state_nxt != state || p_inc) begin
        blink_cnt_nxt = '0;
        phase_nxt     = 1'b0;
      end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
        blink_cnt_nxt = '0;
        phase_nxt     = ~phase;
      end else begin
        blink_cnt_nxt = blink_cnt + 1'b1;
      end
    end

    if (phase_nxt) begin
      case (state_nxt)
        SET_HH:  blank_nxt = 6'b110000;
        SET_MM:  blank_nxt = 6'b001100;
        SET_SS:  blank_nxt = 6'b000011;
        default: blank_nxt = 6'b000000;
      endcase
    end
  end

  assign bus.mode     = state;
  assign bus.run      = run_q;
  assign bus.load     = load_q;
  assign bus.time_out = edit;
  assign bus.blank    = blank_q;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed vector table, blink/glitch/reset corner
// sequences, then random button presses against a field-level model.
module tb_clock_set_ctrl;
  localparam int DB = 4, BH = 8, TO = 100;
  localparam int OP_MODE = 1, OP_INC = 2, OP_BOTH = 3, OP_IDLE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clock_set_ctrl_if ifc();

  clock_set_ctrl #(.DEBOUNCE_CYCLES(DB), .BLINK_HALF(BH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .bus(ifc.slave));

  int checks = 0, errors = 0;
  int loads = 0;
  logic [23:0] last_lval = 24'h0;

  typedef struct {
    int          op;
    logic [23:0] tin;
    logic [1:0]  mode;
    logic        run;
    logic [23:0] tout;
    int          nloads;
    logic [23:0] lval;
  } vec_t;
  vec_t tbl[$];

  // field-level model state
  int m_mode = 0, hh = 0, mm = 0, ss = 0, exp_loads = 0;
  logic [23:0] exp_lval = 24'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ifc.load === 1'b1) begin
      loads++;
      last_lval = ifc.time_out;
      chk("load_with_run_mode", {ifc.run, 6'd0, ifc.mode}, 32'h100);
    end
  end

  function automatic logic [7:0] to_bcd(input int v);
    int x;
    x = (v / 10) * 16 + (v % 10);
    return x[7:0];
  endfunction

  function automatic int sanitize(input logic [7:0] b, input int mx);
    int t, u;
    t = int'(b[7:4]);
    u = int'(b[3:0]);
    if (t > 9 || u > 9 || t * 10 + u > mx) return 0;
    return t * 10 + u;
  endfunction

  function automatic logic [23:0] model_time();
    return {to_bcd(hh), to_bcd(mm), to_bcd(ss)};
  endfunction

  task automatic model_press(input bit m, input bit i, input logic [23:0] tin);
    if (m) begin
      case (m_mode)
        0: begin
          hh = sanitize(tin[23:16], 23);
          mm = sanitize(tin[15:8], 59);
          ss = sanitize(tin[7:0], 59);
          m_mode = 1;
        end
        1: m_mode = 2;
        2: m_mode = 3;
        default: begin
          exp_loads++;
          exp_lval = model_time();
          m_mode = 0;
        end
      endcase
    end else if (i) begin
      case (m_mode)
        1: hh = (hh + 1) % 24;
        2: mm = (mm + 1) % 60;
        3: ss = 0;
        default: ;
      endcase
    end
  endtask

  task automatic press(input bit m, input bit i);
    @(negedge clk);
    ifc.btn_mode = m;
    ifc.btn_inc  = i;
    repeat (10) @(negedge clk);
    ifc.btn_mode = 1'b0;
    ifc.btn_inc  = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic row(input int op, input logic [23:0] tin, input logic [1:0] md, input logic rn,
                     input logic [23:0] tout, input int nl, input logic [23:0] lv);
    vec_t v;
    v.op = op; v.tin = tin; v.mode = md; v.run = rn; v.tout = tout; v.nloads = nl; v.lval = lv;
    tbl.push_back(v);
  endtask

  task automatic blink_check();
    logic [5:0] s[56];
    int k;
    for (int j = 0; j < 56; j++) begin
      @(negedge clk);
      s[j] = ifc.blank;
    end
    k = -1;
    for (int j = 1; j < 24; j++)
      if (k < 0 && s[j] == 6'b110000 && s[j-1] == 6'b000000) k = j;
    if (k < 0) begin
      chk("blink_edge_found", 32'd0, 32'd1);
    end else begin
      for (int j = k; j < k + 32; j++)
        chk("blink_hh", {26'd0, s[j]}, (((j - k) / 8) % 2 == 0) ? 32'h30 : 32'h0);
    end
  endtask

  initial begin
    ifc.btn_mode = 1'b0;
    ifc.btn_inc  = 1'b0;
    ifc.time_in  = 24'h123456;

    // directed table: op, time_in, mode, run, time_out, loads so far, last load value
    row(OP_MODE, 24'h123456, 2'd1, 1'b0, 24'h123456, 0, 24'h000000);
    row(OP_MODE, 24'h123456, 2'd2, 1'b0, 24'h123456, 0, 24'h000000);
    row(OP_MODE, 24'h123456, 2'd3, 1'b0, 24'h123456, 0, 24'h000000);
    row(OP_MODE, 24'h123456, 2'd0, 1'b1, 24'h123456, 1, 24'h123456);
    row(OP_INC,  24'h123456, 2'd0, 1'b1, 24'h123456, 1, 24'h123456);
    row(OP_MODE, 24'h225512, 2'd1, 1'b0, 24'h225512, 1, 24'h123456);
    row(OP_INC,  24'h225512, 2'd1, 1'b0, 24'h235512, 1, 24'h123456);
    row(OP_INC,  24'h225512, 2'd1, 1'b0, 24'h005512, 1, 24'h123456);
    row(OP_INC,  24'h225512, 2'd1, 1'b0, 24'h015512, 1, 24'h123456);
    row(OP_MODE, 24'h225512, 2'd2, 1'b0, 24'h015512, 1, 24'h123456);
    row(OP_INC,  24'h225512, 2'd2, 1'b0, 24'h015612, 1, 24'h123456);
    row(OP_INC,  24'h225512, 2'd2, 1'b0, 24'h015712, 1, 24'h123456);
    row(OP_INC,  24'h225512, 2'd2, 1'b0, 24'h015812, 1, 24'h123456);
    row(OP_INC,  24'h225512, 2'd2, 1'b0, 24'h015912, 1, 24'h123456);
    row(OP_INC,  24'h225512, 2'd2, 1'b0, 24'h010012, 1, 24'h123456);
    row(OP_INC,  24'h225512, 2'd2, 1'b0, 24'h010112, 1, 24'h123456);
    row(OP_INC,  24'h225512, 2'd2, 1'b0, 24'h010212, 1, 24'h123456);
    row(OP_INC,  24'h225512, 2'd2, 1'b0, 24'h010312, 1, 24'h123456);
    row(OP_INC,  24'h225512, 2'd2, 1'b0, 24'h010412, 1, 24'h123456);
    row(OP_INC,  24'h225512, 2'd2, 1'b0, 24'h010512, 1, 24'h123456);
    row(OP_MODE, 24'h225512, 2'd3, 1'b0, 24'h010512, 1, 24'h123456);
    row(OP_MODE, 24'h225512, 2'd0, 1'b1, 24'h010512, 2, 24'h010512);
    row(OP_MODE, 24'h123456, 2'd1, 1'b0, 24'h123456, 2, 24'h010512);
    row(OP_MODE, 24'h123456, 2'd2, 1'b0, 24'h123456, 2, 24'h010512);
    row(OP_IDLE, 24'h123456, 2'd0, 1'b1, 24'h123456, 2, 24'h010512);
    row(OP_MODE, 24'h2A6199, 2'd1, 1'b0, 24'h000000, 2, 24'h010512);
    row(OP_BOTH, 24'h2A6199, 2'd2, 1'b0, 24'h000000, 2, 24'h010512);
    row(OP_INC,  24'h2A6199, 2'd2, 1'b0, 24'h000100, 2, 24'h010512);
    row(OP_MODE, 24'h2A6199, 2'd3, 1'b0, 24'h000100, 2, 24'h010512);
    row(OP_MODE, 24'h2A6199, 2'd0, 1'b1, 24'h000100, 3, 24'h000100);
    row(OP_MODE, 24'h235959, 2'd1, 1'b0, 24'h235959, 3, 24'h000100);
    row(OP_INC,  24'h235959, 2'd1, 1'b0, 24'h005959, 3, 24'h000100);
    row(OP_MODE, 24'h235959, 2'd2, 1'b0, 24'h005959, 3, 24'h000100);
    row(OP_INC,  24'h235959, 2'd2, 1'b0, 24'h000059, 3, 24'h000100);
    row(OP_MODE, 24'h235959, 2'd3, 1'b0, 24'h000059, 3, 24'h000100);
    row(OP_INC,  24'h235959, 2'd3, 1'b0, 24'h000000, 3, 24'h000100);
    row(OP_MODE, 24'h235959, 2'd0, 1'b1, 24'h000000, 4, 24'h000000);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_mode",  {30'd0, ifc.mode}, 32'd0);
    chk("reset_run",   {31'd0, ifc.run},  32'd1);
    chk("reset_load",  {31'd0, ifc.load}, 32'd0);
    chk("reset_blank", {26'd0, ifc.blank}, 32'd0);
    chk("reset_tout",  {8'd0, ifc.time_out}, 32'd0);

    // a 2-cycle blip is shorter than the debounce window
    ifc.btn_mode = 1'b1;
    repeat (2) @(negedge clk);
    ifc.btn_mode = 1'b0;
    repeat (15) @(negedge clk);
    chk("glitch_mode", {30'd0, ifc.mode}, 32'd0);
    chk("glitch_run",  {31'd0, ifc.run},  32'd1);

    for (int k = 0; k < tbl.size(); k++) begin
      ifc.time_in = tbl[k].tin;
      if (tbl[k].op == OP_IDLE) repeat (TO + 20) @(negedge clk);
      else press(tbl[k].op == OP_MODE || tbl[k].op == OP_BOTH,
                 tbl[k].op == OP_INC  || tbl[k].op == OP_BOTH);
      chk($sformatf("vec%0d_mode", k), {30'd0, ifc.mode}, {30'd0, tbl[k].mode});
      chk($sformatf("vec%0d_run", k),  {31'd0, ifc.run},  {31'd0, tbl[k].run});
      chk($sformatf("vec%0d_tout", k), {8'd0, ifc.time_out}, {8'd0, tbl[k].tout});
      chk($sformatf("vec%0d_loads", k), loads, tbl[k].nloads);
      chk($sformatf("vec%0d_lval", k), {8'd0, last_lval}, {8'd0, tbl[k].lval});
      if (tbl[k].mode == 2'd0) chk($sformatf("vec%0d_blank", k), {26'd0, ifc.blank}, 32'd0);
      if (k == 25) blink_check();
    end

    // random presses against the model, from a fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    loads = 0;
    m_mode = 0; hh = 0; mm = 0; ss = 0; exp_loads = 0;
    last_lval = 24'h0; exp_lval = 24'h0;
    for (int n = 0; n < 60; n++) begin
      int r;
      bit m, i;
      r = int'($urandom_range(0, 9));
      m = (r < 4) || (r == 9);
      i = (r >= 4);
      if ($urandom_range(0, 1) == 0)
        ifc.time_in = {to_bcd(int'($urandom_range(0, 23))), to_bcd(int'($urandom_range(0, 59))),
                       to_bcd(int'($urandom_range(0, 59)))};
      else
        ifc.time_in = 24'($urandom);
      press(m, i);
      model_press(m, i, ifc.time_in);
      chk("rnd_mode",  {30'd0, ifc.mode}, m_mode);
      chk("rnd_run",   {31'd0, ifc.run},  (m_mode == 0) ? 32'd1 : 32'd0);
      chk("rnd_tout",  {8'd0, ifc.time_out}, {8'd0, model_time()});
      chk("rnd_loads", loads, exp_loads);
      chk("rnd_lval",  {8'd0, last_lval}, {8'd0, exp_lval});
    end

    // asynchronous reset in the middle of an edit
    if (m_mode == 0) begin
      press(1'b1, 1'b0);
      model_press(1'b1, 1'b0, ifc.time_in);
    end
    chk("pre_rst_run", {31'd0, ifc.run}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_mode",  {30'd0, ifc.mode}, 32'd0);
    chk("async_rst_run",   {31'd0, ifc.run},  32'd1);
    chk("async_rst_tout",  {8'd0, ifc.time_out}, 32'd0);
    chk("async_rst_blank", {26'd0, ifc.blank}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("async_rst_noload", loads, exp_loads);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
